inst_buffer: RTL and testbench

- Dual-slot instruction FIFO between the fetch stage and the decoder group (2R, 2RI12, 1RI20 and related decoders).
- Accepts up to two fetched instructions per cycle, each with its PC and fetch-exception tag.
- Presents up to two in-order head entries to the decode stage.
- Decouples fetch from decode stalls and is cleared on pipeline flush (branch mispredict or exception).

---
 rtl/inst_buffer.sv | 86 ++++++++
 tb/tb_inst_buffer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/inst_buffer.sv
// inst_buffer: dual-slot in-order instruction FIFO between fetch and decode.
// Pushes and pops up to two entries per cycle; an excepting head issues alone.
module inst_buffer #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [1:0]       in_valid,
    input  logic [31:0]      in_pc0,
    input  logic [31:0]      in_pc1,
    input  logic [31:0]      in_inst0,
    input  logic [31:0]      in_inst1,
    input  logic [1:0]       in_exc,
    input  logic [6:0]       in_exc_cause0,
    input  logic [6:0]       in_exc_cause1,
    output logic             in_ready,
    output logic [1:0]       out_valid,
    output logic [31:0]      out_pc0,
    output logic [31:0]      out_pc1,
    output logic [31:0]      out_inst0,
    output logic [31:0]      out_inst1,
    output logic [1:0]       out_exc,
    output logic [6:0]       out_exc_cause0,
    output logic [6:0]       out_exc_cause1,
    input  logic [1:0]       pop,
    output logic [PTR_W:0]   count
);
    logic [31:0]      r_pc    [DEPTH];
    logic [31:0]      r_inst  [DEPTH];
    logic [6:0]       r_cause [DEPTH];
    logic [DEPTH-1:0] r_exc;
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;
    logic [PTR_W-1:0] w_h1;
    logic [PTR_W-1:0] w_t1;
    logic [1:0]       w_npush;
    logic [1:0]       w_npop;

    assign w_h1 = r_head + PTR_W'(1);
    assign w_t1 = r_tail + PTR_W'(1);
    assign count = r_count;
    assign in_ready = r_count <= (PTR_W+1)'(DEPTH - 2);
    assign out_valid[0] = r_count != '0;
    assign out_valid[1] = r_count > (PTR_W+1)'(1) && !r_exc[r_head];
    assign out_pc0 = out_valid[0] ? r_pc[r_head] : '0;
    assign out_inst0 = out_valid[0] ? r_inst[r_head] : '0;
    assign out_exc[0] = out_valid[0] & r_exc[r_head];
    assign out_exc_cause0 = out_valid[0] ? r_cause[r_head] : '0;
    assign out_pc1 = out_valid[1] ? r_pc[w_h1] : '0;
    assign out_inst1 = out_valid[1] ? r_inst[w_h1] : '0;
    assign out_exc[1] = out_valid[1] & r_exc[w_h1];
    assign out_exc_cause1 = out_valid[1] ? r_cause[w_h1] : '0;
    // in_valid=10 is illegal and pushes nothing
    assign w_npush = (!in_ready || !in_valid[0]) ? 2'd0 : in_valid[1] ? 2'd2 : 2'd1;
    assign w_npop = (!pop[0] || !out_valid[0]) ? 2'd0 : (pop[1] && out_valid[1]) ? 2'd2 : 2'd1;

    always_ff @(posedge clk) begin
        if (w_npush != 2'd0) begin
            r_pc[r_tail] <= in_pc0;
            r_inst[r_tail] <= in_inst0;
            r_exc[r_tail] <= in_exc[0];
            r_cause[r_tail] <= in_exc_cause0;
        end
        if (w_npush == 2'd2) begin
            r_pc[w_t1] <= in_pc1;
            r_inst[w_t1] <= in_inst1;
            r_exc[w_t1] <= in_exc[1];
            r_cause[w_t1] <= in_exc_cause1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_head <= '0;
            r_tail <= '0;
            r_count <= '0;
        end else begin
            r_head <= r_head + PTR_W'(w_npop);
            r_tail <= r_tail + PTR_W'(w_npush);
            r_count <= r_count + (PTR_W+1)'(w_npush) - (PTR_W+1)'(w_npop);
        end
    end
endmodule

// File: tb/tb_inst_buffer.sv
// tb_inst_buffer: queue-model scoreboard for inst_buffer with directed corners
// followed by randomized push/pop/flush traffic.
module tb_inst_buffer;
    localparam int DEPTH = 16;
    localparam int PTR_W = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        exc;
        logic [6:0]  cause;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic [1:0] in_valid = '0;
    logic [31:0] in_pc0 = '0, in_pc1 = '0, in_inst0 = '0, in_inst1 = '0;
    logic [1:0] in_exc = '0;
    logic [6:0] in_exc_cause0 = '0, in_exc_cause1 = '0;
    logic [1:0] pop = '0;
    logic in_ready;
    logic [1:0] out_valid, out_exc;
    logic [31:0] out_pc0, out_pc1, out_inst0, out_inst1;
    logic [6:0] out_exc_cause0, out_exc_cause1;
    logic [PTR_W:0] count;

    int checks = 0;
    int errors = 0;
    bit armed = 0;
    ent_t q[$];
    logic [31:0] next_pc = 32'h1c00_0000;

    inst_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
        .in_pc0(in_pc0), .in_pc1(in_pc1), .in_inst0(in_inst0), .in_inst1(in_inst1),
        .in_exc(in_exc), .in_exc_cause0(in_exc_cause0), .in_exc_cause1(in_exc_cause1),
        .in_ready(in_ready), .out_valid(out_valid),
        .out_pc0(out_pc0), .out_pc1(out_pc1), .out_inst0(out_inst0), .out_inst1(out_inst1),
        .out_exc(out_exc), .out_exc_cause0(out_exc_cause0), .out_exc_cause1(out_exc_cause1),
        .pop(pop), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compare DUT against the queue model, then apply this cycle's inputs to it.
    always @(negedge clk) begin
        int n;
        bit ov0, ov1, rdy;
        ent_t z, e0, e1;
        n = q.size();
        z = '{pc: 32'h0, inst: 32'h0, exc: 1'b0, cause: 7'h0};
        ov0 = n >= 1;
        ov1 = n >= 2 && !q[0].exc;
        e0 = ov0 ? q[0] : z;
        e1 = ov1 ? q[1] : z;
        rdy = n <= DEPTH - 2;
        if (armed) begin
            chk("count", 32'(count), 32'(n));
            chk("count_le_depth", 32'(count <= DEPTH), 32'd1);
            chk("in_ready", 32'(in_ready), 32'(rdy));
            chk("out_valid", 32'(out_valid), 32'({ov1, ov0}));
            chk("out_pc0", out_pc0, e0.pc);
            chk("out_inst0", out_inst0, e0.inst);
            chk("out_exc0", 32'(out_exc[0]), 32'(e0.exc));
            chk("out_cause0", 32'(out_exc_cause0), 32'(e0.cause));
            chk("out_pc1", out_pc1, e1.pc);
            chk("out_inst1", out_inst1, e1.inst);
            chk("out_exc1", 32'(out_exc[1]), 32'(e1.exc));
            chk("out_cause1", 32'(out_exc_cause1), 32'(e1.cause));
        end
        if (rst) begin
            q.delete();
            armed = 1;
        end else if (flush) begin
            q.delete();
        end else begin
            if (pop[0] && ov0) begin
                void'(q.pop_front());
                if (pop[1] && ov1) void'(q.pop_front());
            end
            if (rdy && in_valid[0]) begin
                q.push_back('{pc: in_pc0, inst: in_inst0, exc: in_exc[0], cause: in_exc_cause0});
                if (in_valid[1])
                    q.push_back('{pc: in_pc1, inst: in_inst1, exc: in_exc[1], cause: in_exc_cause1});
            end
        end
    end

    task automatic step(input logic [1:0] iv, input logic [1:0] p, input logic f, input logic [1:0] ex);
        in_valid = iv;
        pop = p;
        flush = f;
        in_exc = ex;
        in_pc0 = next_pc;
        in_pc1 = next_pc + 32'd4;
        in_inst0 = $urandom;
        in_inst1 = $urandom;
        in_exc_cause0 = ex[0] ? 7'h08 : 7'($urandom);
        in_exc_cause1 = 7'($urandom);
        if (iv[0]) next_pc = next_pc + (iv[1] ? 32'd8 : 32'd4);
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        // first pair of instructions
        in_valid = 2'b11; pop = 2'b00;
        in_pc0 = 32'h1c00_0000; in_inst0 = 32'h0280_0421;
        in_pc1 = 32'h1c00_0004; in_inst1 = 32'h0380_c842;
        @(posedge clk); #1;
        next_pc = 32'h1c00_0008;
        step(2'b00, 2'b00, 1'b0, 2'b00);
        // fill to 15, drop a push while full, then drain two
        step(2'b01, 2'b00, 1'b0, 2'b00);
        repeat (7) step(2'b11, 2'b00, 1'b0, 2'b00);
        step(2'b11, 2'b11, 1'b0, 2'b00);
        step(2'b00, 2'b00, 1'b0, 2'b00);
        // excepting head is issued alone
        step(2'b00, 2'b00, 1'b1, 2'b00);
        step(2'b11, 2'b00, 1'b0, 2'b01);
        step(2'b00, 2'b00, 1'b0, 2'b00);
        step(2'b00, 2'b11, 1'b0, 2'b00);
        step(2'b00, 2'b00, 1'b0, 2'b00);
        // protocol corners
        step(2'b10, 2'b00, 1'b0, 2'b00);
        step(2'b00, 2'b10, 1'b0, 2'b00);
        step(2'b00, 2'b01, 1'b0, 2'b00);
        // steady state streaming across the wrap point
        step(2'b00, 2'b00, 1'b1, 2'b00);
        repeat (2) step(2'b11, 2'b00, 1'b0, 2'b00);
        repeat (40) step(2'b11, 2'b11, 1'b0, 2'b00);
        // flush beats concurrent push and pop at count 6
        step(2'b00, 2'b00, 1'b1, 2'b00);
        repeat (3) step(2'b11, 2'b00, 1'b0, 2'b00);
        step(2'b11, 2'b11, 1'b1, 2'b00);
        step(2'b00, 2'b00, 1'b0, 2'b00);
        // random traffic
        for (int i = 0; i < 600; i++) begin
            logic [1:0] iv, p, ex;
            iv = 2'($urandom);
            p = 2'($urandom);
            ex = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
            if (i == 300) rst = 1'b1;
            step(iv, p, ($urandom_range(0, 31) == 0), ex);
            rst = 1'b0;
        end
        step(2'b00, 2'b00, 1'b0, 2'b00);
        @(posedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
